// File: rtl/jtag_dma_engine_pkg.sv
// jtag_dma_pkg: shared FSM states, buffer geometry and command encodings for the chain-1 DMA path
package jtag_dma_pkg;
  localparam int BUF_WORDS = 256;
  localparam int IDX_W = $clog2(BUF_WORDS) + 1;
  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_READ = 1'b1;
  typedef enum logic [2:0] {
    S_IDLE, S_REQUEST, S_BEGIN, S_WRITE_DATA, S_READ_DATA, S_END, S_ABORT
  } dma_state_e;
  function automatic logic [7:0] sat_count(input logic [IDX_W-1:0] n);
    return n > IDX_W'(8'hFF) ? 8'hFF : n[7:0];
  endfunction
endpackage

// File: rtl/jtag_dma_engine_if.sv
// jtag_dma_engine_if: Gecko bus master/slave signal bundle
interface jtag_dma_engine_if;
  logic bus_request, bus_grant, begin_transaction_out;
  logic [31:0] address_data_out, address_data_in;
  logic [3:0] byte_enable_out;
  logic [7:0] burst_size_out;
  logic read_n_write_out, data_valid_out, data_valid_in;
  logic end_transaction_out, end_transaction_in, busy_in, error_in;
  modport master(
    output bus_request, begin_transaction_out, address_data_out, byte_enable_out, burst_size_out,
           read_n_write_out, data_valid_out, end_transaction_out,
    input bus_grant, address_data_in, data_valid_in, end_transaction_in, busy_in, error_in
  );
  modport slave(
    input bus_request, begin_transaction_out, address_data_out, byte_enable_out, burst_size_out,
          read_n_write_out, data_valid_out, end_transaction_out,
    output bus_grant, address_data_in, data_valid_in, end_transaction_in, busy_in, error_in
  );
endinterface

// File: rtl/jtag_dma_engine_watchdog.sv
// dma_watchdog: reloadable down-counter flagging TIMEOUT_CYCLES cycles without bus progress
module dma_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic system_clk,
  input  logic n_reset,
  input  logic enable,
  input  logic progress,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYCLES);
  logic [W-1:0] count;
  assign expired = enable && !progress && count == '0;
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) count <= '0;
    else count <= (!enable || progress) ? W'(TIMEOUT_CYCLES - 1) : count - W'(count != '0);
  end
endmodule

// File: rtl/jtag_dma_engine.sv
// jtag_dma_engine: moves one burst between the DMA-side ping-pong half and the Gecko bus
module jtag_dma_engine
  import jtag_dma_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        system_clk,
  input  logic        n_reset,
  input  logic [31:0] DMA_address,
  input  logic [3:0]  DMA_byte_enable,
  input  logic [7:0]  DMA_burst_size_IN,
  input  logic        DMA_launch_write,
  input  logic        DMA_launch_read,
  output logic        DMA_busy,
  output logic [7:0]  DMA_block_size_OUT,
  output logic        dma_error,
  output logic [8:0]  pp_address,
  output logic        pp_writeEnable,
  output logic [31:0] pp_dataIn,
  input  logic [31:0] pp_dataOut,
  jtag_dma_engine_if.master bus
);
  dma_state_e state;
  logic [31:0] addr;
  logic [3:0] be;
  logic [7:0] burst;
  logic rnw, granted, wr_accept, rd_beat, last_wr, progress, wd_en, expired, abort;
  logic [IDX_W-1:0] idx;
  assign wr_accept = state == S_WRITE_DATA && !bus.busy_in;
  assign rd_beat = state == S_READ_DATA && bus.data_valid_in && !bus.error_in && idx <= {1'b0, burst};
  assign last_wr = wr_accept && idx == {1'b0, burst};
  assign wd_en = state inside {S_REQUEST, S_BEGIN, S_WRITE_DATA, S_READ_DATA};
  assign progress = (state == S_REQUEST && bus.bus_grant) || wr_accept ||
                    (state == S_READ_DATA && bus.data_valid_in);
  assign abort = expired || (bus.error_in && state inside {S_BEGIN, S_WRITE_DATA, S_READ_DATA});
  dma_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .system_clk(system_clk),
    .n_reset(n_reset),
    .enable(wd_en),
    .progress(progress),
    .expired(expired)
  );
  assign DMA_busy = state != S_IDLE;
  assign bus.bus_request = state == S_REQUEST;
  assign bus.begin_transaction_out = state == S_BEGIN;
  assign bus.address_data_out = state == S_BEGIN ? addr : state == S_WRITE_DATA ? pp_dataOut : '0;
  assign bus.byte_enable_out = state == S_BEGIN ? be : '0;
  assign bus.burst_size_out = state == S_BEGIN ? burst : '0;
  assign bus.read_n_write_out = state == S_BEGIN && rnw == CMD_READ;
  assign bus.data_valid_out = state == S_WRITE_DATA;
  assign bus.end_transaction_out = (state == S_END && rnw == CMD_WRITE) || (state == S_ABORT && granted);
  // Prefetch the next word on acceptance so pp_dataOut always holds the beat being presented
  assign pp_address = state == S_WRITE_DATA ? {1'b0, wr_accept ? idx[7:0] + 8'd1 : idx[7:0]} :
                      state == S_READ_DATA ? {1'b0, idx[7:0]} : '0;
  assign pp_writeEnable = rd_beat;
  assign pp_dataIn = rd_beat ? bus.address_data_in : '0;
  always_ff @(posedge system_clk or negedge n_reset) begin
    if (!n_reset) begin
      state <= S_IDLE;
      addr <= '0;
      be <= '0;
      burst <= '0;
      rnw <= CMD_WRITE;
      granted <= 1'b0;
      idx <= '0;
      DMA_block_size_OUT <= '0;
      dma_error <= 1'b0;
    end else if (abort) begin
      state <= S_ABORT;
      dma_error <= 1'b1;
      DMA_block_size_OUT <= rnw == CMD_READ ? sat_count(idx) : 8'h00;
    end else begin
      case (state)
        S_IDLE: if (DMA_launch_write || DMA_launch_read) begin
          state <= S_REQUEST;
          addr <= {DMA_address[31:2], 2'b00};
          be <= DMA_byte_enable;
          burst <= DMA_burst_size_IN;
          rnw <= DMA_launch_write ? CMD_WRITE : CMD_READ;
          dma_error <= 1'b0;
          granted <= 1'b0;
          idx <= '0;
        end
        S_REQUEST: if (bus.bus_grant) begin
          granted <= 1'b1;
          state <= S_BEGIN;
        end
        S_BEGIN: state <= rnw == CMD_READ ? S_READ_DATA : S_WRITE_DATA;
        S_WRITE_DATA: begin
          if (wr_accept) idx <= idx + IDX_W'(1);
          if (last_wr) begin
            state <= S_END;
            DMA_block_size_OUT <= 8'h00;
          end
        end
        S_READ_DATA: begin
          if (rd_beat) idx <= idx + IDX_W'(1);
          if (bus.end_transaction_in) begin
            state <= S_END;
            DMA_block_size_OUT <= sat_count(idx + IDX_W'(rd_beat));
          end
        end
        default: begin
          state <= S_IDLE;
          granted <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_jtag_dma_engine.sv
// tb_jtag_dma_engine: randomized Gecko-slave and buffer model checking bursts, aborts and launch rules
module tb_jtag_dma_engine;
  localparam int TO = 16;
  logic system_clk = 1'b0;
  logic n_reset = 1'b0;
  logic [31:0] DMA_address = '0;
  logic [3:0] DMA_byte_enable = '0;
  logic [7:0] DMA_burst_size_IN = '0;
  logic DMA_launch_write = 1'b0, DMA_launch_read = 1'b0;
  logic DMA_busy, dma_error, pp_writeEnable;
  logic [7:0] DMA_block_size_OUT;
  logic [8:0] pp_address;
  logic [31:0] pp_dataIn;
  logic [31:0] pp_dataOut = '0;
  int n_cmp = 0, n_bad = 0;
  int begin_cnt = 0, end_cnt = 0, beat_cnt = 0, wr_cnt = 0;
  bit addr_bad = 1'b0;
  logic [31:0] begin_addr;
  logic [3:0] begin_be;
  logic [7:0] begin_bs;
  logic begin_rnw;
  logic [31:0] beat_log[1024];
  logic [31:0] rbuf[256];
  logic [31:0] wsrc[512];
  logic [31:0] rdata[256];

  jtag_dma_engine_if bus();
  jtag_dma_engine #(.TIMEOUT_CYCLES(TO)) dut (
    .system_clk(system_clk), .n_reset(n_reset),
    .DMA_address(DMA_address), .DMA_byte_enable(DMA_byte_enable),
    .DMA_burst_size_IN(DMA_burst_size_IN), .DMA_launch_write(DMA_launch_write),
    .DMA_launch_read(DMA_launch_read), .DMA_busy(DMA_busy),
    .DMA_block_size_OUT(DMA_block_size_OUT), .dma_error(dma_error),
    .pp_address(pp_address), .pp_writeEnable(pp_writeEnable), .pp_dataIn(pp_dataIn),
    .pp_dataOut(pp_dataOut), .bus(bus)
  );

  always #5 system_clk = ~system_clk;
  always @(posedge system_clk) pp_dataOut <= wsrc[pp_address];

  // Bus and buffer observers, sampled mid-cycle
  always @(negedge system_clk) if (n_reset) begin
    if (bus.begin_transaction_out) begin
      begin_cnt++;
      begin_addr = bus.address_data_out;
      begin_be = bus.byte_enable_out;
      begin_bs = bus.burst_size_out;
      begin_rnw = bus.read_n_write_out;
    end
    if (bus.end_transaction_out) end_cnt++;
    if (bus.data_valid_out && !bus.busy_in) begin
      beat_log[beat_cnt % 1024] = bus.address_data_out;
      beat_cnt++;
    end
    if (pp_writeEnable) begin
      rbuf[pp_address[7:0]] = pp_dataIn;
      if (pp_address[8]) addr_bad = 1'b1;
      wr_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic step();
    @(posedge system_clk);
    #1;
  endtask

  task automatic launch(input bit w, input bit r, input logic [31:0] a, input logic [3:0] be,
                        input logic [7:0] bs);
    DMA_address = a;
    DMA_byte_enable = be;
    DMA_burst_size_IN = bs;
    DMA_launch_write = w;
    DMA_launch_read = r;
    step();
    DMA_launch_write = 1'b0;
    DMA_launch_read = 1'b0;
  endtask

  // Gecko slave: grants after grant_dly request cycles, stalls/gaps, returns rd_words read beats
  task automatic serve(input int grant_dly, input bit give_grant, input int stall_beat,
                       input int stall_len, input bit gaps, input int rd_words, input int err_beat,
                       input int relaunch_at, output int cyc, output bit to);
    int k = 0, req = 0, stall = stall_len;
    bit in_rd = 1'b0, done = 1'b0;
    cyc = 0;
    to = 1'b0;
    while (DMA_busy) begin
      if (cyc >= 3000) begin
        to = 1'b1;
        break;
      end
      bus.bus_grant = give_grant && bus.bus_request && req >= grant_dly;
      if (bus.bus_request) req++;
      bus.busy_in = 1'b0;
      if (bus.data_valid_out) begin
        if (k == stall_beat && stall > 0) begin
          bus.busy_in = 1'b1;
          stall--;
        end else if (gaps && $urandom_range(3) == 0) bus.busy_in = 1'b1;
        if (!bus.busy_in) k++;
      end
      bus.data_valid_in = 1'b0;
      bus.end_transaction_in = 1'b0;
      bus.error_in = 1'b0;
      if (in_rd && !done) begin
        if (k == err_beat) begin
          bus.error_in = 1'b1;
          done = 1'b1;
        end else if (k < rd_words) begin
          if (!(gaps && $urandom_range(3) == 0)) begin
            bus.data_valid_in = 1'b1;
            bus.address_data_in = rdata[k];
            k++;
          end
        end else begin
          bus.end_transaction_in = 1'b1;
          done = 1'b1;
        end
      end
      if (bus.begin_transaction_out && bus.read_n_write_out) in_rd = 1'b1;
      DMA_launch_read = cyc == relaunch_at;
      step();
      cyc++;
    end
    bus.bus_grant = 1'b0;
    bus.busy_in = 1'b0;
    bus.data_valid_in = 1'b0;
    bus.end_transaction_in = 1'b0;
    bus.error_in = 1'b0;
    DMA_launch_read = 1'b0;
  endtask

  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) step();
    n_cmp++;
    if ({DMA_busy, DMA_block_size_OUT, dma_error, pp_address, pp_writeEnable, bus.bus_request,
         bus.begin_transaction_out, bus.data_valid_out, bus.end_transaction_out} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: busy=%b bs=%0h err=%b ppa=%0h we=%b req=%b", DMA_busy,
               DMA_block_size_OUT, dma_error, pp_address, pp_writeEnable, bus.bus_request);
    end
    n_reset = 1'b1;
    step();
    n_cmp++;
    if (DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_busy: got %b want 0", DMA_busy);
    end
  endtask

  task automatic test_write(input bit rnd);
    logic [31:0] a = rnd ? $urandom : 32'h0000_1000;
    logic [3:0] be = rnd ? 4'($urandom) : 4'hF;
    logic [7:0] bs = rnd ? 8'($urandom_range(15)) : 8'd3;
    int b0 = beat_cnt, bc0 = begin_cnt, e0 = end_cnt, w0 = wr_cnt, cyc;
    bit to;
    for (int i = 0; i < 256; i++) wsrc[i] = rnd ? $urandom : 32'hA0 + i;
    launch(1'b1, 1'b0, a, be, bs);
    n_cmp++;
    if (DMA_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL write_busy_after_launch: got %b want 1", DMA_busy);
    end
    serve(rnd ? int'($urandom_range(5)) : 2, 1'b1, 1, rnd ? 0 : 2, rnd, 0, -1, -1, cyc, to);
    n_cmp++;
    if (to || DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL write_done: busy=%b timed_out=%b want busy 0", DMA_busy, to);
    end
    n_cmp++;
    if (beat_cnt - b0 !== int'(bs) + 1) begin
      n_bad++;
      $display("FAIL write_beat_count: got %0d want %0d", beat_cnt - b0, int'(bs) + 1);
    end
    for (int i = 0; i <= int'(bs); i++) begin
      n_cmp++;
      if (beat_log[(b0 + i) % 1024] !== wsrc[i]) begin
        n_bad++;
        $display("FAIL write_beat[%0d]: got %h want %h", i, beat_log[(b0 + i) % 1024], wsrc[i]);
      end
    end
    n_cmp++;
    if (begin_cnt - bc0 !== 1 || begin_addr !== (a & ~32'h3) || begin_be !== be ||
        begin_bs !== bs || begin_rnw !== 1'b0) begin
      n_bad++;
      $display("FAIL write_begin: n=%0d addr=%h be=%h bs=%0d rnw=%b want 1 %h %h %0d 0",
               begin_cnt - bc0, begin_addr, begin_be, begin_bs, begin_rnw, a & ~32'h3, be, bs);
    end
    n_cmp++;
    if (end_cnt - e0 !== 1 || wr_cnt !== w0) begin
      n_bad++;
      $display("FAIL write_end: ends=%0d bufwrites=%0d want 1 0", end_cnt - e0, wr_cnt - w0);
    end
    n_cmp++;
    if (DMA_block_size_OUT !== 8'h00 || dma_error !== 1'b0) begin
      n_bad++;
      $display("FAIL write_status: block=%0d err=%b want 0 0", DMA_block_size_OUT, dma_error);
    end
  endtask

  task automatic test_read(input int bs, input int rd, input bit gaps);
    int n = rd < bs + 1 ? rd : bs + 1;
    int w0 = wr_cnt, e0 = end_cnt, cyc;
    bit to;
    logic [31:0] a = $urandom;
    for (int i = 0; i < 256; i++) rdata[i] = $urandom;
    launch(1'b0, 1'b1, a, 4'hF, 8'(bs));
    serve(int'($urandom_range(3)), 1'b1, -1, 0, gaps, rd, -1, -1, cyc, to);
    n_cmp++;
    if (to || DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL read_done: busy=%b timed_out=%b want busy 0", DMA_busy, to);
    end
    n_cmp++;
    if (wr_cnt - w0 !== n || addr_bad) begin
      n_bad++;
      $display("FAIL read_writes: got %0d addr8=%b want %0d 0", wr_cnt - w0, addr_bad, n);
    end
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (rbuf[i] !== rdata[i]) begin
        n_bad++;
        $display("FAIL read_buf[%0d]: got %h want %h", i, rbuf[i], rdata[i]);
      end
    end
    n_cmp++;
    if (DMA_block_size_OUT !== 8'(n > 255 ? 255 : n) || dma_error !== 1'b0 || end_cnt !== e0) begin
      n_bad++;
      $display("FAIL read_status: block=%0d err=%b ends=%0d want %0d 0 0", DMA_block_size_OUT,
               dma_error, end_cnt - e0, n > 255 ? 255 : n);
    end
    n_cmp++;
    if (begin_rnw !== 1'b1 || begin_addr !== (a & ~32'h3)) begin
      n_bad++;
      $display("FAIL read_begin: rnw=%b addr=%h want 1 %h", begin_rnw, begin_addr, a & ~32'h3);
    end
  endtask

  task automatic test_timeout();
    int e0 = end_cnt, cyc;
    bit to;
    launch(1'b1, 1'b0, 32'h40, 4'hF, 8'd2);
    serve(0, 1'b0, -1, 0, 1'b0, 0, -1, -1, cyc, to);
    n_cmp++;
    if (to || cyc !== TO + 1) begin
      n_bad++;
      $display("FAIL timeout_len: busy cycles %0d want %0d", cyc, TO + 1);
    end
    n_cmp++;
    if (dma_error !== 1'b1 || DMA_busy !== 1'b0 || end_cnt !== e0) begin
      n_bad++;
      $display("FAIL timeout_status: err=%b busy=%b ends=%0d want 1 0 0", dma_error, DMA_busy,
               end_cnt - e0);
    end
    launch(1'b1, 1'b0, 32'h80, 4'hF, 8'd0);
    n_cmp++;
    if (dma_error !== 1'b0) begin
      n_bad++;
      $display("FAIL relaunch_clears_error: got %b want 0", dma_error);
    end
    serve(1, 1'b1, -1, 0, 1'b0, 0, -1, -1, cyc, to);
    n_cmp++;
    if (to || dma_error !== 1'b0 || DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL relaunch_done: err=%b busy=%b want 0 0", dma_error, DMA_busy);
    end
  endtask

  task automatic test_error();
    int e0 = end_cnt, w0 = wr_cnt, cyc;
    bit to;
    for (int i = 0; i < 256; i++) rdata[i] = $urandom;
    launch(1'b0, 1'b1, 32'h200, 4'hF, 8'd5);
    serve(1, 1'b1, -1, 0, 1'b0, 6, 2, -1, cyc, to);
    n_cmp++;
    if (to || DMA_block_size_OUT !== 8'd2 || dma_error !== 1'b1 || DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL error_status: block=%0d err=%b busy=%b want 2 1 0", DMA_block_size_OUT,
               dma_error, DMA_busy);
    end
    n_cmp++;
    if (end_cnt - e0 !== 1 || wr_cnt - w0 !== 2 || rbuf[0] !== rdata[0] || rbuf[1] !== rdata[1]) begin
      n_bad++;
      $display("FAIL error_side: ends=%0d writes=%0d want 1 2", end_cnt - e0, wr_cnt - w0);
    end
  endtask

  task automatic test_launch_rules();
    int bc0 = begin_cnt, b0 = beat_cnt, cyc;
    bit to;
    for (int i = 0; i < 256; i++) wsrc[i] = $urandom;
    launch(1'b1, 1'b1, 32'h300, 4'h3, 8'd4);
    serve(2, 1'b1, -1, 0, 1'b1, 0, -1, 3, cyc, to);
    repeat (3) step();
    n_cmp++;
    if (to || begin_cnt - bc0 !== 1 || begin_rnw !== 1'b0 || DMA_busy !== 1'b0) begin
      n_bad++;
      $display("FAIL launch_rules: begins=%0d rnw=%b busy=%b want 1 0 0", begin_cnt - bc0,
               begin_rnw, DMA_busy);
    end
    n_cmp++;
    if (beat_cnt - b0 !== 5 || beat_log[(b0 + 4) % 1024] !== wsrc[4]) begin
      n_bad++;
      $display("FAIL launch_rules_beats: got %0d want 5", beat_cnt - b0);
    end
  endtask

  task automatic test_reset_mid();
    int d = 0;
    launch(1'b0, 1'b1, 32'h500, 4'hF, 8'd20);
    for (int c = 0; c < 100 && d < 5; c++) begin
      bus.bus_grant = bus.bus_request;
      if (bus.begin_transaction_out) d = 1;
      else if (d > 0) begin
        bus.data_valid_in = 1'b1;
        bus.address_data_in = $urandom;
        d++;
      end
      step();
    end
    n_cmp++;
    if (DMA_busy !== 1'b1 || pp_writeEnable !== 1'b1) begin
      n_bad++;
      $display("FAIL midburst_active: busy=%b we=%b want 1 1", DMA_busy, pp_writeEnable);
    end
    n_reset = 1'b0;
    #1;
    n_cmp++;
    if ({DMA_busy, DMA_block_size_OUT, dma_error, pp_address, pp_writeEnable, pp_dataIn,
         bus.bus_request, bus.begin_transaction_out, bus.address_data_out, bus.byte_enable_out,
         bus.burst_size_out, bus.read_n_write_out, bus.data_valid_out, bus.end_transaction_out} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: busy=%b block=%0d err=%b ppa=%0h we=%b want all 0", DMA_busy,
               DMA_block_size_OUT, dma_error, pp_address, pp_writeEnable);
    end
    bus.data_valid_in = 1'b0;
    bus.bus_grant = 1'b0;
    step();
    n_reset = 1'b1;
    step();
  endtask

  initial begin
    bus.bus_grant = 1'b0;
    bus.address_data_in = '0;
    bus.data_valid_in = 1'b0;
    bus.end_transaction_in = 1'b0;
    bus.busy_in = 1'b0;
    bus.error_in = 1'b0;
    for (int i = 0; i < 512; i++) wsrc[i] = '0;
    test_reset();
    test_write(1'b0);
    test_read(7, 8, 1'b1);
    test_write(1'b1);
    for (int i = 0; i < 3; i++) begin
      int bs = int'($urandom_range(20));
      test_read(bs, int'($urandom_range(1, bs + 4)), 1'b1);
    end
    test_write(1'b1);
    test_read(255, 256, 1'b1);
    test_timeout();
    test_error();
    test_launch_rules();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
